msi_cpu_controller: RTL and testbench

//   Processor-side MSI coherence controller for a small direct-mapped cache. Holds per-line

---
 rtl/msi_cpu_controller_pkg.sv | 40 ++++
 rtl/msi_cpu_controller_if.sv | 35 +++
 rtl/msi_cpu_controller_line_array.sv | 44 ++++
 rtl/msi_cpu_controller.sv | 156 +++++++++++++++
 tb/tb_msi_cpu_controller.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/msi_cpu_controller_pkg.sv
// Shared types for the processor-side MSI controller: line-state codes, bus action
// codes, FSM states and the per-line record held in the line array.
package msi_cpu_controller_pkg;

    localparam int LINES = 4;
    localparam int IDX_W = 2;
    localparam int TAG_W = 6;

    typedef enum logic [1:0] {
        ST_INVALID   = 2'b00,
        ST_SHARED    = 2'b01,
        ST_EXCLUSIVE = 2'b10
    } line_st_t;

    typedef enum logic [1:0] {
        BA_READ_MISS  = 2'b00,
        BA_INVALIDATE = 2'b01,
        BA_WRITE_MISS = 2'b10,
        BA_NULL       = 2'b11
    } bus_act_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_WB,
        S_ISSUE,
        S_RESP
    } fsm_t;

    typedef struct packed {
        line_st_t         st;
        logic [TAG_W-1:0] tag;
    } line_t;

    // A line "matches" only when it holds valid data for the given tag.
    function automatic logic line_match(line_t l, logic [TAG_W-1:0] t);
        return (l.st != ST_INVALID) && (l.tag == t);
    endfunction

endpackage

// File: rtl/msi_cpu_controller_if.sv
// CPU port, bus port and snoop-event signals of the MSI controller, grouped as one bundle.
interface msi_cpu_controller_if;
    import msi_cpu_controller_pkg::*;

    logic             cpu_req;
    logic             cpu_we;
    logic [IDX_W-1:0] cpu_index;
    logic [TAG_W-1:0] cpu_tag;
    logic             cpu_ready;
    logic             cpu_hit;
    logic             bus_req;
    logic             bus_grant;
    logic             bus_done;
    logic [1:0]       bus_acao;
    logic [TAG_W-1:0] bus_tag;
    logic             writeback;
    logic             snoop_valid;
    logic [1:0]       snoop_acao;
    logic [IDX_W-1:0] snoop_index;
    logic [TAG_W-1:0] snoop_tag;

    // slave = the controller; master = CPU, arbiter and snoop side driving it
    modport slave (
        input  cpu_req, cpu_we, cpu_index, cpu_tag, bus_grant, bus_done,
               snoop_valid, snoop_acao, snoop_index, snoop_tag,
        output cpu_ready, cpu_hit, bus_req, bus_acao, bus_tag, writeback
    );

    modport master (
        output cpu_req, cpu_we, cpu_index, cpu_tag, bus_grant, bus_done,
               snoop_valid, snoop_acao, snoop_index, snoop_tag,
        input  cpu_ready, cpu_hit, bus_req, bus_acao, bus_tag, writeback
    );

endinterface

// File: rtl/msi_cpu_controller_line_array.sv
// LINES x {state, tag} storage with one combinational lookup port, one write port and
// one snoop-update port. A local write to the same line overrides a snoop update.
module msi_line_array
    import msi_cpu_controller_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IDX_W-1:0] i_lk_idx,
    output line_t            o_lk_line,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  line_t            i_wr_line,
    input  logic             i_snp_en,
    input  logic [1:0]       i_snp_acao,
    input  logic [IDX_W-1:0] i_snp_idx,
    input  logic [TAG_W-1:0] i_snp_tag
);

    line_t r_lines [LINES];
    line_t w_snp_line;

    assign o_lk_line  = r_lines[i_lk_idx];
    assign w_snp_line = r_lines[i_snp_idx];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < LINES; i++)
                r_lines[i] <= '{st: ST_INVALID, tag: '0};
        end else begin
            if (i_snp_en && line_match(w_snp_line, i_snp_tag)) begin
                // remote read only strips exclusivity; remote write/upgrade kills the line
                if (i_snp_acao == BA_READ_MISS) begin
                    if (w_snp_line.st == ST_EXCLUSIVE)
                        r_lines[i_snp_idx].st <= ST_SHARED;
                end else if (i_snp_acao != BA_NULL) begin
                    r_lines[i_snp_idx].st <= ST_INVALID;
                end
            end
            if (i_wr_en)
                r_lines[i_wr_idx] <= i_wr_line;
        end
    end

endmodule

// File: rtl/msi_cpu_controller.sv
// Processor-side MSI controller: looks up CPU requests, arbitrates for the bus, writes
// back dirty victims, issues the coherence action and installs the line on completion.
module msi_cpu_controller
    import msi_cpu_controller_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    msi_cpu_controller_if.slave  bus
);

    fsm_t             r_state;
    bus_act_t         r_pending;
    logic             r_wb_pending;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic [TAG_W-1:0] r_vtag;
    logic             r_cpu_ready;
    logic             r_cpu_hit;
    logic             r_bus_req;
    bus_act_t         r_bus_acao;
    logic [TAG_W-1:0] r_bus_tag;
    logic             r_writeback;

    logic [IDX_W-1:0] w_lk_idx;
    line_t            w_line;
    logic             w_lk_hit;
    logic             w_snp_clash;
    logic             w_snp_kill;
    bus_act_t         w_pending_eff;
    logic             w_wb_eff;
    logic             w_wr_en;
    line_t            w_wr_line;
    logic             w_snp_en;

    assign w_lk_idx    = (r_state == S_IDLE) ? bus.cpu_index : r_idx;
    assign w_lk_hit    = line_match(w_line, bus.cpu_tag);
    assign w_snp_clash = bus.snoop_valid && (bus.snoop_index == bus.cpu_index);

    // A remote write/upgrade hitting our line while we wait for the bus: an upgrade
    // must become a full write miss, and a dirty victim no longer needs writing back.
    assign w_snp_kill    = bus.snoop_valid && (bus.snoop_index == r_idx)
                         && ((bus.snoop_acao == BA_INVALIDATE) || (bus.snoop_acao == BA_WRITE_MISS))
                         && line_match(w_line, bus.snoop_tag);
    assign w_pending_eff = (r_pending == BA_INVALIDATE && w_snp_kill) ? BA_WRITE_MISS : r_pending;
    assign w_wb_eff      = r_wb_pending && !w_snp_kill;

    // While the bus is ours in RESP, the local install wins over snoops on this line.
    assign w_snp_en = bus.snoop_valid && !(r_state == S_RESP && bus.snoop_index == r_idx);
    assign w_wr_en  = (r_state == S_WB) || (r_state == S_RESP && bus.bus_done);

    always_comb begin
        w_wr_line = '{st: ST_INVALID, tag: r_vtag};
        if (r_state == S_RESP)
            w_wr_line = '{st: (r_pending == BA_READ_MISS) ? ST_SHARED : ST_EXCLUSIVE, tag: r_tag};
    end

    msi_line_array u_lines (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_lk_idx   (w_lk_idx),
        .o_lk_line  (w_line),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (r_idx),
        .i_wr_line  (w_wr_line),
        .i_snp_en   (w_snp_en),
        .i_snp_acao (bus.snoop_acao),
        .i_snp_idx  (bus.snoop_index),
        .i_snp_tag  (bus.snoop_tag)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_pending    <= BA_NULL;
            r_wb_pending <= 1'b0;
            r_idx        <= '0;
            r_tag        <= '0;
            r_vtag       <= '0;
            r_cpu_ready  <= 1'b0;
            r_cpu_hit    <= 1'b0;
            r_bus_req    <= 1'b0;
            r_bus_acao   <= BA_NULL;
            r_bus_tag    <= '0;
            r_writeback  <= 1'b0;
        end else begin
            r_cpu_ready <= 1'b0;
            r_cpu_hit   <= 1'b0;
            r_writeback <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // r_cpu_ready guard: the CPU still shows the finished request this cycle
                    if (bus.cpu_req && !r_cpu_ready && !w_snp_clash) begin
                        r_idx        <= bus.cpu_index;
                        r_tag        <= bus.cpu_tag;
                        r_vtag       <= w_line.tag;
                        r_wb_pending <= 1'b0;
                        if (w_lk_hit && (!bus.cpu_we || w_line.st == ST_EXCLUSIVE)) begin
                            r_cpu_ready <= 1'b1;
                            r_cpu_hit   <= 1'b1;
                        end else begin
                            r_bus_req <= 1'b1;
                            r_state   <= S_ARB;
                            if (w_lk_hit) begin
                                r_pending <= BA_INVALIDATE;
                            end else begin
                                r_pending    <= bus.cpu_we ? BA_WRITE_MISS : BA_READ_MISS;
                                r_wb_pending <= (w_line.st == ST_EXCLUSIVE);
                            end
                        end
                    end
                end
                S_ARB: begin
                    r_pending    <= w_pending_eff;
                    r_wb_pending <= w_wb_eff;
                    if (bus.bus_grant) begin
                        if (w_wb_eff) begin
                            r_state     <= S_WB;
                            r_writeback <= 1'b1;
                            r_bus_acao  <= BA_NULL;
                            r_bus_tag   <= r_vtag;
                        end else begin
                            r_state    <= S_ISSUE;
                            r_bus_acao <= w_pending_eff;
                            r_bus_tag  <= r_tag;
                        end
                    end
                end
                S_WB: begin
                    r_state    <= S_ISSUE;
                    r_bus_acao <= r_pending;
                    r_bus_tag  <= r_tag;
                end
                S_ISSUE: begin
                    r_state    <= S_RESP;
                    r_bus_acao <= BA_NULL;
                end
                S_RESP: begin
                    if (bus.bus_done) begin
                        r_cpu_ready <= 1'b1;
                        r_bus_req   <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cpu_ready = r_cpu_ready;
    assign bus.cpu_hit   = r_cpu_hit;
    assign bus.bus_req   = r_bus_req;
    assign bus.bus_acao  = r_bus_acao;
    assign bus.bus_tag   = r_bus_tag;
    assign bus.writeback = r_writeback;

endmodule

// File: tb/tb_msi_cpu_controller.sv
// Directed bench for msi_cpu_controller: hits, misses, upgrades, writebacks, snoop
// interactions and reset mid-transaction, with hand-computed expected values.
module tb_msi_cpu_controller;
    import msi_cpu_controller_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    msi_cpu_controller_if bi ();

    msi_cpu_controller dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One CPU transaction; the bench plays arbiter (grant after gdly ARB cycles), memory
    // (done after ddly RESP cycles) and optionally a one-cycle snoop at cycle sc.
    task automatic run_txn(input logic we, input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag,
                           input int gdly, input int ddly, input int sc, input logic [1:0] sacao,
                           input logic [IDX_W-1:0] sidx, input logic [TAG_W-1:0] stag,
                           output logic hit, output logic [1:0] acao, output logic [TAG_W-1:0] btag,
                           output logic wb, output logic [TAG_W-1:0] wbtag, output logic breq,
                           output int cyc);
        int   gw;
        int   dw;
        logic issued;
        hit = 0; acao = 2'b11; btag = '0; wb = 0; wbtag = '0; breq = 0; cyc = 0;
        gw = gdly; dw = 0; issued = 0;
        @(negedge clk);
        bi.cpu_req = 1; bi.cpu_we = we; bi.cpu_index = idx; bi.cpu_tag = tag;
        bi.snoop_valid = (sc == 0); bi.snoop_acao = sacao; bi.snoop_index = sidx; bi.snoop_tag = stag;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            bi.snoop_valid = (sc == cyc);
            bi.bus_done = 0;
            if (bi.cpu_ready) begin
                hit = bi.cpu_hit;
                break;
            end
            if (bi.bus_req) breq = 1;
            if (bi.writeback) begin wb = 1; wbtag = bi.bus_tag; end
            if (bi.bus_acao != 2'b11) begin
                acao = bi.bus_acao; btag = bi.bus_tag; issued = 1; dw = ddly;
            end else if (issued) begin
                if (dw == 0) begin bi.bus_done = 1; issued = 0; end
                else dw--;
            end
            if (bi.bus_req && !bi.bus_grant) begin
                if (gw == 0) bi.bus_grant = 1;
                else gw--;
            end
        end
        bi.cpu_req = 0; bi.bus_grant = 0; bi.bus_done = 0; bi.snoop_valid = 0;
    endtask

    task automatic pulse_snoop(input logic [1:0] a, input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tag);
        @(negedge clk);
        bi.snoop_valid = 1; bi.snoop_acao = a; bi.snoop_index = idx; bi.snoop_tag = tag;
        @(negedge clk);
        bi.snoop_valid = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        @(negedge clk);
        n_cmp++; if (bi.cpu_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bi.cpu_ready); end
        n_cmp++; if (bi.cpu_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit: got %b want 0", bi.cpu_hit); end
        n_cmp++; if (bi.bus_req !== 1'b0) begin n_err++; $display("FAIL reset_bus_req: got %b want 0", bi.bus_req); end
        n_cmp++; if (bi.bus_acao !== 2'b11) begin n_err++; $display("FAIL reset_acao: got %b want 11", bi.bus_acao); end
        n_cmp++; if (bi.bus_tag !== 6'd0) begin n_err++; $display("FAIL reset_bus_tag: got %0d want 0", bi.bus_tag); end
        n_cmp++; if (bi.writeback !== 1'b0) begin n_err++; $display("FAIL reset_writeback: got %b want 0", bi.writeback); end
        rst = 0;
    endtask

    task automatic test_read_miss_then_hit;
        logic h, wb, br; logic [1:0] a; logic [5:0] bt, wt; int c;
        run_txn(0, 2'd0, 6'd5, 0, 0, -1, 2'b11, 2'd0, 6'd0, h, a, bt, wb, wt, br, c);
        n_cmp++; if (c !== 4) begin n_err++; $display("FAIL rdmiss_latency: got %0d want 4", c); end
        n_cmp++; if (h !== 1'b0) begin n_err++; $display("FAIL rdmiss_hit: got %b want 0", h); end
        n_cmp++; if (a !== 2'b00) begin n_err++; $display("FAIL rdmiss_acao: got %b want 00", a); end
        n_cmp++; if (bt !== 6'd5) begin n_err++; $display("FAIL rdmiss_tag: got %0d want 5", bt); end
        n_cmp++; if (wb !== 1'b0) begin n_err++; $display("FAIL rdmiss_wb: got %b want 0", wb); end
        run_txn(0, 2'd0, 6'd5, 0, 0, -1, 2'b11, 2'd0, 6'd0, h, a, bt, wb, wt, br, c);
        n_cmp++; if (c !== 1) begin n_err++; $display("FAIL rdhit_latency: got %0d want 1", c); end
        n_cmp++; if (h !== 1'b1) begin n_err++; $display("FAIL rdhit_hit: got %b want 1", h); end
        n_cmp++; if (br !== 1'b0) begin n_err++; $display("FAIL rdhit_bus_req: got %b want 0", br); end
    endtask

    task automatic test_write_upgrade;
        logic h, wb, br; logic [1:0] a; logic [5:0] bt, wt; int c;
        run_txn(1, 2'd0, 6'd5, 1, 2, -1, 2'b11, 2'd0, 6'd0, h, a, bt, wb, wt, br, c);
        n_cmp++; if (a !== 2'b01) begin n_err++; $display("FAIL upg_acao: got %b want 01", a); end
        n_cmp++; if (c !== 7) begin n_err++; $display("FAIL upg_latency: got %0d want 7", c); end
        n_cmp++; if (h !== 1'b0) begin n_err++; $display("FAIL upg_hit: got %b want 0", h); end
        run_txn(1, 2'd0, 6'd5, 0, 0, -1, 2'b11, 2'd0, 6'd0, h, a, bt, wb, wt, br, c);
        n_cmp++; if (h !== 1'b1 || c !== 1) begin n_err++; $display("FAIL wrhit_excl: got hit %b lat %0d want 1/1", h, c); end
        n_cmp++; if (br !== 1'b0) begin n_err++; $display("FAIL wrhit_bus_req: got %b want 0", br); end
    endtask

    task automatic test_writeback;
        logic h, wb, br; logic [1:0] a; logic [5:0] bt, wt; int c;
        run_txn(0, 2'd0, 6'd9, 0, 0, -1, 2'b11, 2'd0, 6'd0, h, a, bt, wb, wt, br, c);
        n_cmp++; if (wb !== 1'b1) begin n_err++; $display("FAIL wb_pulse: got %b want 1", wb); end
        n_cmp++; if (wt !== 6'd5) begin n_err++; $display("FAIL wb_tag: got %0d want 5", wt); end
        n_cmp++; if (a !== 2'b00 || bt !== 6'd9) begin n_err++; $display("FAIL wb_issue: got %b/%0d want 00/9", a, bt); end
        n_cmp++; if (c !== 5) begin n_err++; $display("FAIL wb_latency: got %0d want 5", c); end
        run_txn(0, 2'd0, 6'd9, 0, 0, -1, 2'b11, 2'd0, 6'd0, h, a, bt, wb, wt, br, c);
        n_cmp++; if (h !== 1'b1) begin n_err++; $display("FAIL wb_newline_hit: got %b want 1", h); end
        run_txn(1, 2'd0, 6'd9, 0, 0, -1, 2'b11, 2'd0, 6'd0, h, a, bt, wb, wt, br, c);
        n_cmp++; if (a !== 2'b01) begin n_err++; $display("FAIL wb_newline_shared: got %b want 01", a); end
    endtask

    task automatic test_snoop_in_arb;
        logic h, wb, br; logic [1:0] a; logic [5:0] bt, wt; int c;
        run_txn(0, 2'd1, 6'd3, 0, 0, -1, 2'b11, 2'd0, 6'd0, h, a, bt, wb, wt, br, c);
        n_cmp++; if (a !== 2'b00) begin n_err++; $display("FAIL arb_fill_acao: got %b want 00", a); end
        run_txn(1, 2'd1, 6'd3, 2, 0, 1, 2'b10, 2'd1, 6'd3, h, a, bt, wb, wt, br, c);
        n_cmp++; if (a !== 2'b10) begin n_err++; $display("FAIL arb_upg_to_wrmiss: got %b want 10", a); end
        n_cmp++; if (c !== 6) begin n_err++; $display("FAIL arb_upg_latency: got %0d want 6", c); end
        run_txn(1, 2'd1, 6'd3, 0, 0, -1, 2'b11, 2'd0, 6'd0, h, a, bt, wb, wt, br, c);
        n_cmp++; if (h !== 1'b1) begin n_err++; $display("FAIL arb_line_excl: got %b want 1", h); end
        // line0 is tag9 exclusive: a remote invalidate during ARB cancels its writeback
        run_txn(0, 2'd0, 6'd12, 2, 0, 1, 2'b01, 2'd0, 6'd9, h, a, bt, wb, wt, br, c);
        n_cmp++; if (wb !== 1'b0) begin n_err++; $display("FAIL arb_wb_cancel: got %b want 0", wb); end
        n_cmp++; if (a !== 2'b00 || bt !== 6'd12) begin n_err++; $display("FAIL arb_wb_cancel_issue: got %b/%0d want 00/12", a, bt); end
        n_cmp++; if (c !== 6) begin n_err++; $display("FAIL arb_wb_cancel_latency: got %0d want 6", c); end
    endtask

    task automatic test_snoop_updates;
        logic h, wb, br; logic [1:0] a; logic [5:0] bt, wt; int c;
        // snoop on the requested index in IDLE delays the lookup by one cycle
        run_txn(0, 2'd0, 6'd12, 0, 0, 0, 2'b11, 2'd0, 6'd12, h, a, bt, wb, wt, br, c);
        n_cmp++; if (h !== 1'b1 || c !== 2) begin n_err++; $display("FAIL idle_retry: got hit %b lat %0d want 1/2", h, c); end
        pulse_snoop(2'b00, 2'd1, 6'd3);
        run_txn(1, 2'd1, 6'd3, 0, 0, -1, 2'b11, 2'd0, 6'd0, h, a, bt, wb, wt, br, c);
        n_cmp++; if (a !== 2'b01 || c !== 4) begin n_err++; $display("FAIL snoop_downgrade: got %b lat %0d want 01/4", a, c); end
        pulse_snoop(2'b10, 2'd0, 6'd12);
        run_txn(0, 2'd0, 6'd12, 0, 0, -1, 2'b11, 2'd0, 6'd0, h, a, bt, wb, wt, br, c);
        n_cmp++; if (h !== 1'b0 || a !== 2'b00) begin n_err++; $display("FAIL snoop_invalidate: got hit %b acao %b want 0/00", h, a); end
        pulse_snoop(2'b00, 2'd0, 6'd7);
        run_txn(0, 2'd0, 6'd12, 0, 0, -1, 2'b11, 2'd0, 6'd0, h, a, bt, wb, wt, br, c);
        n_cmp++; if (h !== 1'b1) begin n_err++; $display("FAIL snoop_tag_mismatch: got %b want 1", h); end
    endtask

    task automatic test_reset_mid;
        logic h, wb, br; logic [1:0] a; logic [5:0] bt, wt; int c;
        int   k;
        @(negedge clk);
        bi.cpu_req = 1; bi.cpu_we = 0; bi.cpu_index = 2'd2; bi.cpu_tag = 6'd7;
        k = 0;
        while (k < 20 && bi.bus_acao == 2'b11) begin
            @(negedge clk);
            k++;
            if (bi.bus_req) bi.bus_grant = 1;
        end
        n_cmp++; if (k >= 20) begin n_err++; $display("FAIL rstmid_issue_timeout: got %0d cycles want <20", k); end
        @(negedge clk);
        n_cmp++; if (bi.bus_req !== 1'b1) begin n_err++; $display("FAIL rstmid_in_resp: got %b want 1", bi.bus_req); end
        rst = 1;
        #1;
        n_cmp++; if (bi.bus_req !== 1'b0) begin n_err++; $display("FAIL rstmid_bus_req: got %b want 0", bi.bus_req); end
        n_cmp++; if (bi.bus_acao !== 2'b11 || bi.cpu_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_outputs: got %b/%b want 11/0", bi.bus_acao, bi.cpu_ready); end
        bi.cpu_req = 0; bi.bus_grant = 0;
        @(negedge clk);
        rst = 0;
        run_txn(0, 2'd0, 6'd12, 0, 0, -1, 2'b11, 2'd0, 6'd0, h, a, bt, wb, wt, br, c);
        n_cmp++; if (h !== 1'b0 || a !== 2'b00 || c !== 4) begin n_err++; $display("FAIL rstmid_line0_miss: got hit %b acao %b lat %0d want 0/00/4", h, a, c); end
        run_txn(0, 2'd1, 6'd3, 0, 0, -1, 2'b11, 2'd0, 6'd0, h, a, bt, wb, wt, br, c);
        n_cmp++; if (h !== 1'b0 || wb !== 1'b0) begin n_err++; $display("FAIL rstmid_line1_miss: got hit %b wb %b want 0/0", h, wb); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0; rst = 1;
        bi.cpu_req = 0; bi.cpu_we = 0; bi.cpu_index = '0; bi.cpu_tag = '0;
        bi.bus_grant = 0; bi.bus_done = 0;
        bi.snoop_valid = 0; bi.snoop_acao = 2'b11; bi.snoop_index = '0; bi.snoop_tag = '0;
        test_reset;
        test_read_miss_then_hit;
        test_write_upgrade;
        test_writeback;
        test_snoop_in_arb;
        test_snoop_updates;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
